// File: rtl/spatial_encoder_multimodal.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spatial_encoder_multimodal: per-modality channel bundling + majority fusion|
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module spatial_encoder_multimodal #(
  parameter int HV_DIMENSION  = 2000,
  parameter int CHANNEL_WIDTH = 8,
  parameter int NUM_MOD       = 3,
  parameter int MAX_CHANNELS  = 256,
  parameter int ADDR_WIDTH    = 8
) (
  input  logic                              Clk_CI,
  input  logic                              Reset_RI,
  input  logic                              ValidIn_SI,
  output logic                              ReadyOut_SO,
  input  logic [CHANNEL_WIDTH*MAX_CHANNELS-1:0] ChannelsInput_DI,
  input  logic [NUM_MOD*ADDR_WIDTH-1:0]     ModChannels_DI,
  output logic [ADDR_WIDTH-1:0]             SramAddr_DO,
  output logic [NUM_MOD-1:0]                SramReq_SO,
  input  logic [NUM_MOD-1:0]                SramValid_SI,
  input  logic [NUM_MOD*HV_DIMENSION-1:0]   IM_DI,
  input  logic [NUM_MOD*HV_DIMENSION-1:0]   ProjPos_DI,
  input  logic [NUM_MOD*HV_DIMENSION-1:0]   ProjNeg_DI,
  output logic [HV_DIMENSION-1:0]           HypervectorOut_DO,
  output logic                              Error_SO,
  output logic                              ValidOut_SO,
  input  logic                              ReadyIn_SI
);

  localparam int EW        = $clog2(NUM_MOD + 1);
  localparam int SUM_WIDTH = ADDR_WIDTH + EW;
  localparam int CW        = ADDR_WIDTH + 1;
  localparam logic [SUM_WIDTH-1:0] MAX_CH = SUM_WIDTH'(MAX_CHANNELS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CHANNEL_WIDTH-1:0] feat      [MAX_CHANNELS];
  logic [ADDR_WIDTH-1:0]    mod_cnt   [NUM_MOD];
  logic [ADDR_WIDTH-1:0]    k;
  logic [CW-1:0]            bit_cnt   [NUM_MOD][HV_DIMENSION];
  logic [HV_DIMENSION-1:0]  t0        [NUM_MOD];
  logic [HV_DIMENSION-1:0]  t1        [NUM_MOD];
  logic [HV_DIMENSION-1:0]  hv_q;
  logic                     err_q;

  logic [ADDR_WIDTH-1:0]    in_cnt    [NUM_MOD];
  logic [SUM_WIDTH-1:0]     in_sum;
  logic [EW-1:0]            in_en;
  logic                     cfg_err;

  logic [SUM_WIDTH-1:0]     base      [NUM_MOD];
  logic [SUM_WIDTH-1:0]     acc;
  logic [ADDR_WIDTH-1:0]    cnt_max;
  logic [EW-1:0]            en_num;
  logic [NUM_MOD-1:0]       active;
  logic                     step;
  logic                     last;

  logic [CHANNEL_WIDTH-1:0] feat_sel  [NUM_MOD];
  logic [HV_DIMENSION-1:0]  h         [NUM_MOD];
  logic [HV_DIMENSION-1:0]  fused;

  // Incoming configuration, evaluated only for the accept decision.
  always_comb begin
    in_sum = '0;
    in_en  = '0;
    for (int m = 0; m < NUM_MOD; m++) begin
      in_cnt[m] = ModChannels_DI[(NUM_MOD-1-m)*ADDR_WIDTH +: ADDR_WIDTH];
      in_sum    = in_sum + SUM_WIDTH'(in_cnt[m]);
      if (in_cnt[m] != '0) in_en = in_en + EW'(1);
    end
    cfg_err = (in_sum > MAX_CH);
  end

  always_comb begin
    acc     = '0;
    cnt_max = '0;
    en_num  = '0;
    for (int m = 0; m < NUM_MOD; m++) begin
      base[m]   = acc;
      acc       = acc + SUM_WIDTH'(mod_cnt[m]);
      if (mod_cnt[m] > cnt_max) cnt_max = mod_cnt[m];
      if (mod_cnt[m] != '0) en_num = en_num + EW'(1);
      active[m] = (k < mod_cnt[m]);
    end
    step = (state == RUN) && (&(SramValid_SI | ~active));
    last = (k == cnt_max - ADDR_WIDTH'(1));
  end

  // Channel HV: the active modality's base+k is always below the accepted total.
  always_comb begin
    for (int m = 0; m < NUM_MOD; m++) begin
      feat_sel[m] = feat[ADDR_WIDTH'(base[m] + SUM_WIDTH'(k))];
      h[m] = IM_DI[(NUM_MOD-1-m)*HV_DIMENSION +: HV_DIMENSION];
      if (feat_sel[m][CHANNEL_WIDTH-1])
        h[m] = h[m] ^ ProjNeg_DI[(NUM_MOD-1-m)*HV_DIMENSION +: HV_DIMENSION];
      else if (feat_sel[m] != '0)
        h[m] = h[m] ^ ProjPos_DI[(NUM_MOD-1-m)*HV_DIMENSION +: HV_DIMENSION];
    end
  end

  // Per-modality majority, then cross-modality vote; even ties fall back
  // to T0^T1 inside a modality and to the lowest enabled modality across.
  always_comb begin
    logic [EW-1:0]   ones;
    logic            tie_bit;
    logic            found;
    logic            mb;
    logic [CW:0]     dbl;
    fused = '0;
    for (int b = 0; b < HV_DIMENSION; b++) begin
      ones    = '0;
      tie_bit = 1'b0;
      found   = 1'b0;
      for (int m = 0; m < NUM_MOD; m++) begin
        dbl = {bit_cnt[m][b], 1'b0};
        mb  = 1'b0;
        if (mod_cnt[m] != '0) begin
          if (dbl > {2'b00, mod_cnt[m]})
            mb = 1'b1;
          else if (dbl == {2'b00, mod_cnt[m]})
            mb = t0[m][b] ^ t1[m][b];
          ones = ones + EW'(mb);
          if (!found) begin
            tie_bit = mb;
            found   = 1'b1;
          end
        end
      end
      if ({ones, 1'b0} > {1'b0, en_num})
        fused[b] = 1'b1;
      else if ({ones, 1'b0} == {1'b0, en_num})
        fused[b] = tie_bit;
    end
  end

  always_comb begin
    state_nxt   = state;
    ReadyOut_SO = 1'b0;
    ValidOut_SO = 1'b0;
    SramReq_SO  = '0;
    SramAddr_DO = '0;
    case (state)
      IDLE: begin
        ReadyOut_SO = 1'b1;
        if (ValidIn_SI) begin
          if (cfg_err || (in_en == '0)) state_nxt = OUT;
          else                          state_nxt = RUN;
        end
      end
      RUN: begin
        SramReq_SO  = active;
        SramAddr_DO = k;
        if (step && last) state_nxt = FINAL;
      end
      FINAL: state_nxt = OUT;
      OUT: begin
        ValidOut_SO = 1'b1;
        if (ReadyIn_SI) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      state <= IDLE;
      k     <= '0;
      hv_q  <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < MAX_CHANNELS; i++) feat[i] <= '0;
      for (int m = 0; m < NUM_MOD; m++) begin
        mod_cnt[m] <= '0;
        t0[m]      <= '0;
        t1[m]      <= '0;
        for (int b = 0; b < HV_DIMENSION; b++) bit_cnt[m][b] <= '0;
      end
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (ValidIn_SI) begin
            for (int i = 0; i < MAX_CHANNELS; i++)
              feat[i] <= ChannelsInput_DI[(MAX_CHANNELS-1-i)*CHANNEL_WIDTH +: CHANNEL_WIDTH];
            for (int m = 0; m < NUM_MOD; m++) begin
              mod_cnt[m] <= in_cnt[m];
              for (int b = 0; b < HV_DIMENSION; b++) bit_cnt[m][b] <= '0;
            end
            k     <= '0;
            hv_q  <= '0;
            err_q <= cfg_err;
          end
        end
        RUN: begin
          if (step) begin
            for (int m = 0; m < NUM_MOD; m++) begin
              if (active[m]) begin
                for (int b = 0; b < HV_DIMENSION; b++)
                  bit_cnt[m][b] <= bit_cnt[m][b] + CW'(h[m][b]);
                if (k == ADDR_WIDTH'(0)) t0[m] <= h[m];
                if (k == ADDR_WIDTH'(1)) t1[m] <= h[m];
              end
            end
            if (!last) k <= k + ADDR_WIDTH'(1);
          end
        end
        FINAL: hv_q <= fused;
        default: ;
      endcase
    end
  end

  assign HypervectorOut_DO = hv_q;
  assign Error_SO          = err_q;

endmodule
`default_nettype wire
